// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search helper for the UART frame arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {IDLE, STREAM, GAP} arb_state_t;

   localparam int CLK_HZ  = 50_000_000;
   localparam int MAX_REQ = 8;

   // First set bit of valid searching upward from ptr+1, wrapping modulo n.
   // Walking the offsets from far to near lets the nearest hit overwrite the rest.
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input logic [2:0]         ptr,
                                          input int                 n);
      logic [2:0] pick;
      int         idx;
      pick = ptr;
      for (int i = MAX_REQ; i >= 1; i--) begin
         if (i <= n) begin
            idx = (int'(ptr) + i) % n;
            if (valid[idx[2:0]]) pick = idx[2:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over NUM_REQ valids, starting after ptr_i.
// Zero latency; found_o says whether any requester is valid at all.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [IDW-1:0]     idx_o,
   output logic               found_o
);

   logic [MAX_REQ-1:0] valid_ext;
   logic [2:0]         pick;

   always_comb begin
      valid_ext                = '0;
      valid_ext[NUM_REQ-1:0]   = valid_i;
      pick                     = rr_pick(valid_ext, 3'(ptr_i), NUM_REQ);
   end

   assign idx_o   = IDW'(pick);
   assign found_o = |valid_i;

endmodule

// File: rtl/uart_frame_arbiter.sv
// Frame-granular arbiter sharing one uart_tx between NUM_REQ byte sources; 1-cycle grant,
// zero-cycle byte pass-through, tx_ready forwarded to the owner, idle gap after each frame.
module uart_frame_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int GAP_CLKS     = 5000,
   parameter int TIMEOUT_CLKS = 50000,
   parameter int PRIO0        = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ*8-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int GW  = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
   localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);

   arb_state_t     state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [TW-1:0]  to_q, to_d;

   logic [IDW-1:0] rr_idx;
   logic           rr_found;
   logic           sel_valid, sel_last;
   logic [7:0]     sel_data;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .idx_o   (rr_idx),
      .found_o (rr_found)
   );

   assign sel_valid = req_valid[grant_q];
   assign sel_last  = req_last[grant_q];
   assign sel_data  = req_data[{grant_q, 3'b000} +: 8];

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      gap_d       = gap_q;
      to_d        = to_q;
      tx_valid    = 1'b0;
      tx_data     = '0;
      req_ready   = '0;
      timeout_err = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rr_found) begin
               grant_d = (PRIO0 != 0 && req_valid[0]) ? '0 : rr_idx;
               to_d    = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            tx_valid           = sel_valid;
            tx_data            = sel_data;
            req_ready[grant_q] = tx_ready;
            if (sel_valid && tx_ready) begin
               to_d = '0;
               if (sel_last) begin
                  rr_ptr_d = grant_q;
                  if (GAP_CLKS > 0) begin
                     gap_d   = GAP_LOAD;
                     state_d = GAP;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (!sel_valid) begin
               // Only a silent owner counts toward the drop; a uart_tx stall never does.
               if (to_q >= TO_LAST) begin
                  timeout_err = 1'b1;
                  rr_ptr_d    = grant_q;
                  to_d        = '0;
                  state_d     = IDLE;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= IDW'(NUM_REQ - 1);
         gap_q    <= '0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         gap_q    <= gap_d;
         to_q     <= to_d;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench: A has PRIO0=1 with the full gap, B is plain round-robin with a short gap.
module tb_uart_frame_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] req_data = '0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_last = '0;
   logic        tx_ready = 1'b0;

   logic [1:0] req_ready_a, req_ready_b;
   logic [7:0] tx_data_a, tx_data_b;
   logic       tx_valid_a, tx_valid_b;
   logic       grant_id_a, grant_id_b;
   logic       busy_a, busy_b;
   logic       timeout_err_a, timeout_err_b;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   uart_frame_arbiter #(.NUM_REQ(2), .GAP_CLKS(5000), .TIMEOUT_CLKS(100), .PRIO0(1)) dut_a (
      .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
      .req_ready(req_ready_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
      .grant_id(grant_id_a), .busy(busy_a), .timeout_err(timeout_err_a)
   );

   uart_frame_arbiter #(.NUM_REQ(2), .GAP_CLKS(3), .TIMEOUT_CLKS(100), .PRIO0(0)) dut_b (
      .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
      .req_ready(req_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
      .grant_id(grant_id_b), .busy(busy_b), .timeout_err(timeout_err_b)
   );

   typedef struct {
      logic [1:0] rv, rl;
      logic [7:0] d0, d1;
      logic       tr;
      logic       tv;
      logic [7:0] td;
      logic [1:0] rr;
      logic       g, bz, te;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] rl, input logic [7:0] d0, input logic [7:0] d1,
                      input logic tv, input logic [7:0] td, input logic [1:0] rr,
                      input logic g, input logic bz);
      vec_t v;
      v.rv = 2'b11; v.rl = rl; v.d0 = d0; v.d1 = d1; v.tr = 1'b1;
      v.tv = tv; v.td = td; v.rr = rr; v.g = g; v.bz = bz; v.te = 1'b0;
      vecs.push_back(v);
   endtask

   task automatic do_reset;
      reset = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wait_idle_a(input string name);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         if (!busy_a) begin ok = 1'b1; break; end
      end
      chk(name, ok, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, %0d miscompares so far", nerr);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] msg [3];
      int idx, busy_cnt, pulses, first, bad, errs;
      msg[0] = 8'h7B; msg[1] = 8'h61; msg[2] = 8'h7D;

      // Round-robin table for B: 2-byte frames from both requesters, ready always high.
      add(2'b00, 8'hA0, 8'hB0, 0, 8'h00, 2'b00, 0, 0);
      add(2'b00, 8'hA0, 8'hB0, 1, 8'hA0, 2'b01, 0, 1);
      add(2'b01, 8'hA1, 8'hB0, 1, 8'hA1, 2'b01, 0, 1);
      for (int i = 0; i < 3; i++) add(2'b00, 8'hA0, 8'hB0, 0, 8'h00, 2'b00, 0, 1);
      add(2'b00, 8'hA0, 8'hB0, 0, 8'h00, 2'b00, 0, 0);
      add(2'b00, 8'hA0, 8'hB0, 1, 8'hB0, 2'b10, 1, 1);
      add(2'b10, 8'hA0, 8'hB1, 1, 8'hB1, 2'b10, 1, 1);
      for (int i = 0; i < 3; i++) add(2'b00, 8'hA0, 8'hB0, 0, 8'h00, 2'b00, 1, 1);
      add(2'b00, 8'hA0, 8'hB0, 0, 8'h00, 2'b00, 1, 0);
      add(2'b00, 8'hA0, 8'hB0, 1, 8'hA0, 2'b01, 0, 1);
      add(2'b01, 8'hA1, 8'hB0, 1, 8'hA1, 2'b01, 0, 1);
      for (int i = 0; i < 3; i++) add(2'b00, 8'hA0, 8'hB0, 0, 8'h00, 2'b00, 0, 1);
      add(2'b00, 8'hA0, 8'hB0, 0, 8'h00, 2'b00, 0, 0);
      add(2'b00, 8'hA0, 8'hB0, 1, 8'hB0, 2'b10, 1, 1);
      add(2'b10, 8'hA0, 8'hB1, 1, 8'hB1, 2'b10, 1, 1);
      add(2'b00, 8'hA0, 8'hB0, 0, 8'h00, 2'b00, 1, 1);

      // Reset state of both instances
      do_reset;
      @(negedge clk);
      chk("reset tx_valid_a", tx_valid_a, 0);
      chk("reset req_ready_a", req_ready_a, 0);
      chk("reset busy_a", busy_a, 0);
      chk("reset grant_a", grant_id_a, 0);
      chk("reset timeout_a", timeout_err_a, 0);
      chk("reset tx_valid_b", tx_valid_b, 0);
      chk("reset busy_b", busy_b, 0);
      chk("reset tx_data_b", tx_data_b, 0);
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         req_valid = vecs[i].rv; req_last = vecs[i].rl;
         req_data  = {vecs[i].d1, vecs[i].d0}; tx_ready = vecs[i].tr;
         @(negedge clk);
         chk($sformatf("rr[%0d] tx_valid", i), tx_valid_b, vecs[i].tv);
         chk($sformatf("rr[%0d] tx_data", i), tx_data_b, vecs[i].td);
         chk($sformatf("rr[%0d] req_ready", i), req_ready_b, vecs[i].rr);
         chk($sformatf("rr[%0d] grant", i), grant_id_b, vecs[i].g);
         chk($sformatf("rr[%0d] busy", i), busy_b, vecs[i].bz);
         chk($sformatf("rr[%0d] timeout", i), timeout_err_b, vecs[i].te);
         @(posedge clk); #1;
      end

      // Requester 1 sends "{a}" with ready pulsing every 10 cycles, then the full gap
      do_reset;
      req_valid = 2'b10; req_data[15:8] = msg[0]; req_last = 2'b00;
      @(negedge clk);
      chk("t2 idle tx_valid", tx_valid_a, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2 grant", grant_id_a, 1);
      chk("t2 busy", busy_a, 1);
      @(posedge clk); #1;
      idx = 0;
      for (int cyc = 0; cyc < 100 && idx < 3; cyc++) begin
         req_data[15:8] = msg[idx]; req_last[1] = (idx == 2); tx_ready = (cyc % 10 == 9);
         @(negedge clk);
         if (tx_valid_a && tx_ready) begin
            chk($sformatf("t2 byte%0d", idx), tx_data_a, msg[idx]);
            idx++;
         end
         @(posedge clk); #1;
      end
      req_valid = 2'b00; req_last = 2'b00; tx_ready = 1'b0;
      chk("t2 bytes sent", idx, 3);
      busy_cnt = 0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         if (!busy_a) break;
         busy_cnt++;
      end
      chk("t2 gap busy cycles", busy_cnt, 5000);

      // PRIO0: requester 0 waits for requester 1's frame, then beats round-robin
      do_reset;
      req_valid = 2'b10; req_data = {8'hC0, 8'h00}; req_last = 2'b00; tx_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3 grant1", grant_id_a, 1);
      chk("t3 byte C0", tx_data_a, 8'hC0);
      @(posedge clk); #1;
      req_valid = 2'b11; req_data = {8'hC1, 8'hD0}; req_last = 2'b11;
      @(negedge clk);
      chk("t3 no preempt grant", grant_id_a, 1);
      chk("t3 byte C1", tx_data_a, 8'hC1);
      chk("t3 ready only owner", req_ready_a, 2'b10);
      @(posedge clk); #1;
      req_data = {8'hE0, 8'hD0};
      wait_idle_a("t3 gap1 ends");
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3 grant0 after gap", grant_id_a, 0);
      chk("t3 byte D0", tx_data_a, 8'hD0);
      @(posedge clk); #1;
      req_data = {8'hE0, 8'hD2};
      wait_idle_a("t3 gap2 ends");
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3 prio beats rr", grant_id_a, 0);
      chk("t3 byte D2", tx_data_a, 8'hD2);

      // Timeout: requester 0 goes silent after one byte
      do_reset;
      req_valid = 2'b11; req_data = {8'hF0, 8'hE0}; req_last = 2'b10; tx_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4 grant0", grant_id_a, 0);
      chk("t4 byte E0", tx_data_a, 8'hE0);
      @(posedge clk); #1;
      req_valid = 2'b10;
      pulses = 0; first = 0;
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk);
         if (timeout_err_a) begin
            pulses++;
            if (first == 0) first = k;
         end
         if (k == 101) chk("t4 no gap after drop", busy_a, 0);
         if (k == 102) begin
            chk("t4 next grant", grant_id_a, 1);
            chk("t4 byte F0", tx_data_a, 8'hF0);
         end
      end
      chk("t4 pulse count", pulses, 1);
      chk("t4 pulse cycle", first, 100);

      // Long tx_ready stall with valid high never times out
      do_reset;
      req_valid = 2'b01; req_data = {8'h00, 8'h99}; req_last = 2'b01; tx_ready = 1'b0;
      @(posedge clk); #1;
      bad = 0; errs = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (!tx_valid_b || tx_data_b !== 8'h99 || req_ready_b !== 2'b00) bad++;
         if (timeout_err_b) errs++;
      end
      chk("t5 byte held", bad, 0);
      chk("t5 no timeout", errs, 0);
      @(posedge clk); #1;
      tx_ready = 1'b1;
      @(negedge clk);
      chk("t5 ready forwarded", req_ready_b, 2'b01);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5 frame done", tx_valid_b, 0);
      chk("t5 in gap", busy_b, 1);

      // Asynchronous reset mid-frame
      do_reset;
      req_valid = 2'b01; req_data = {8'h66, 8'h55}; req_last = 2'b00; tx_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6 streaming", tx_valid_b, 1);
      #2 reset = 1'b0;
      #1;
      chk("t6 rst tx_valid_b", tx_valid_b, 0);
      chk("t6 rst tx_data_b", tx_data_b, 0);
      chk("t6 rst req_ready_b", req_ready_b, 0);
      chk("t6 rst busy_b", busy_b, 0);
      chk("t6 rst timeout_b", timeout_err_b, 0);
      chk("t6 rst tx_valid_a", tx_valid_a, 0);
      chk("t6 rst busy_a", busy_a, 0);
      req_valid = 2'b10;
      @(negedge clk); #1 reset = 1'b1;
      chk("t6 idle after release", busy_b, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6 regrant", grant_id_b, 1);
      chk("t6 regrant valid", tx_valid_b, 1);
      chk("t6 regrant data", tx_data_b, 8'h66);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
